// File: rtl/vector_stream_controller.sv
// Streams element pairs into packed vectors, runs one multiplier transaction,
// then streams the packed products back out one element per handshake.
module vector_stream_controller #(
    parameter int VECTOR_SIZE    = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_a,
    input  logic [DATA_WIDTH-1:0]             in_b,
    output logic                              mul_start,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] mul_vector_a,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] mul_vector_b,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] mul_result,
    input  logic                              mul_done,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_last,
    output logic                              busy,
    output logic                              timeout
);

    localparam int IW = $clog2(VECTOR_SIZE);
    localparam int VW = DATA_WIDTH * VECTOR_SIZE;
    localparam int CW = 32;
    localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   tcount;
    logic [CW-1:0]   tcount_inc;
    logic [VW-1:0]   vec_a;
    logic [VW-1:0]   vec_b;
    logic [VW-1:0]   result;
    logic            timeout_flag;
    logic            in_fire;
    logic            out_fire;
    logic            idx_last;
    logic            timeout_hit;

    // Handshakes only ever complete in their own state, so inputs elsewhere are ignored.
    assign in_fire     = in_valid && (state == S_LOAD);
    assign out_fire    = out_ready && (state == S_DRAIN);
    assign idx_last    = (idx == LAST_IDX);
    assign tcount_inc  = tcount + 32'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcount_inc == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:  if (in_fire && idx_last) state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (mul_done) begin
                    state_next = S_DRAIN;
                end else if (timeout_hit) begin
                    state_next = S_LOAD;
                end
            end
            S_DRAIN: if (out_fire && idx_last) state_next = S_LOAD;
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx          <= '0;
            tcount       <= '0;
            vec_a        <= '0;
            vec_b        <= '0;
            result       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        vec_a[idx*DATA_WIDTH +: DATA_WIDTH] <= in_a;
                        vec_b[idx*DATA_WIDTH +: DATA_WIDTH] <= in_b;
                        idx <= idx_last ? '0 : idx + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A done seen on the expiry cycle still wins over the abort.
                    tcount <= tcount_inc;
                    if (mul_done) begin
                        result <= mul_result;
                        tcount <= '0;
                    end else if (timeout_hit) begin
                        timeout_flag <= 1'b1;
                        tcount       <= '0;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        idx <= idx_last ? '0 : idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state == S_LOAD);
    assign mul_start    = (state == S_START);
    assign mul_vector_a = vec_a;
    assign mul_vector_b = vec_b;
    assign out_valid    = (state == S_DRAIN);
    assign out_data     = (state == S_DRAIN) ? result[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign out_last     = (state == S_DRAIN) && idx_last;
    assign busy         = (state != S_LOAD);
    assign timeout      = timeout_flag;

endmodule

// File: doc/vector_stream_controller.md
# vector_stream_controller

Initiator-side sequencer for `vector_multiplier`. It accepts element pairs over a valid/ready input stream and packs them into `vector_a` and `vector_b`. It then issues a one-cycle `start`, waits for `done` with a bounded timeout, captures the packed result and streams the products out one element per handshake. It sits between the streaming datapath and the parallel multiplier, so upstream and downstream logic never handle packed vectors.

## Interface
- `VECTOR_SIZE`, 8: elements per vector; must be ≥ 2.
- `DATA_WIDTH`, 16: bits per element.
- `TIMEOUT_CYCLES`, 1024: maximum number of WAIT cycles before abort; 0 disables the timeout.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `in_valid` input 1: element pair valid.
- `in_ready` output 1: pair accepted when `in_valid && in_ready`.
- `in_a` input DATA_WIDTH: element of vector A.
- `in_b` input DATA_WIDTH: element of vector B.
- `mul_start` output 1: start pulse to the multiplier.
- `mul_vector_a` output DATA_WIDTH*VECTOR_SIZE: packed A.
- `mul_vector_b` output DATA_WIDTH*VECTOR_SIZE: packed B.
- `mul_result` input DATA_WIDTH*VECTOR_SIZE: packed products.
- `mul_done` input 1: multiplier completion (level or pulse).
- `out_valid` output 1: product element valid.
- `out_ready` input 1: downstream accept.
- `out_data` output DATA_WIDTH: product element.
- `out_last` output 1: high with element VECTOR_SIZE-1.
- `busy` output 1: high when state ≠ LOAD.
- `timeout` output 1: sticky abort flag.

## Operation
- States: LOAD → START → WAIT → DRAIN → LOAD.
- **Reset.** `rst_n` is low at a rising edge, in any state. Effect:
  - state = LOAD; element index = 0; timeout counter = 0.
  - Packed A/B registers and the result register are cleared to 0.
  - `timeout` = 0.
  - Resulting outputs: `in_ready`=1, `mul_start`=0, `mul_vector_a`/`mul_vector_b`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
- **LOAD.** `in_ready`=1.
  - The k-th accepted pair (k = 0..VECTOR_SIZE-1) is written to bits [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH] of both packed registers.
  - On the VECTOR_SIZE-th handshake the index returns to 0 and the state moves to START.
- **START.** `mul_start`=1 for exactly this one cycle; `in_ready`=0. Next state is WAIT.
- **WAIT.** `mul_start`=0.
  - The timeout counter increments each cycle.
  - `mul_done`=1 sampled in any WAIT cycle: the full `mul_result` is captured, then DRAIN.
  - Counter reaches TIMEOUT_CYCLES without `mul_done` (and TIMEOUT_CYCLES ≠ 0): `timeout` is set, the result is discarded and the state returns to LOAD.
  - If `mul_done` and timeout expiry occur in the same cycle, `mul_done` wins.
  - The responder must drop any stale `done` by the cycle after `start`.
- **DRAIN.**
  - `out_valid`=1; `out_data` is captured result slice [index].
  - `out_last` = (index == VECTOR_SIZE-1).
  - Each `out_valid && out_ready` advances the index.
  - After the last handshake, the index returns to 0 and the state returns to LOAD.
- **Stability.**
  - `mul_vector_a`/`mul_vector_b` change only on LOAD handshakes. They are stable from START until the next LOAD write.
  - `out_data` and `out_last` are stable while `out_valid && !out_ready`.
- **Widths.** No arithmetic on data: result slices pass through bit-exact, and any truncation belongs to the multiplier.
- **Timeout flag.** `timeout` stays set through later operations until reset.
- **Ignored inputs.**
  - `in_valid` outside LOAD is ignored; data is held upstream by `in_ready`=0.
  - `mul_done` outside WAIT is ignored.

## Timing
- Last input handshake at cycle T gives `mul_start`=1 in T+1, and WAIT from T+2.
- `mul_done` sampled high in cycle D gives `out_valid`=1 with element 0 in D+1.
- Throughput is one element per cycle in LOAD and in DRAIN with no stalls; there are no bubbles between elements.
- Last output handshake at cycle E gives `in_ready`=1 in E+1.
- Timeout: the first WAIT cycle is count 1. `timeout`=1 and `in_ready`=1 appear in the cycle after count TIMEOUT_CYCLES is reached.
- All outputs are registered, or decoded directly from registered state/index; there is no combinational path from input to output.

## Test plan
Parameters: VECTOR_SIZE=8, DATA_WIDTH=16. The responder model asserts `done` 3 cycles after `start`.
- **Sequential data.** Send a=1..8 and b=8..1.
  - `mul_start` is high exactly 1 cycle.
  - `out_data` = 8,14,18,20,20,18,14,8.
  - `out_last` is high only on the 8th element.
  - `busy` falls the cycle after the last output handshake.
- **Backpressure.** Random `in_valid` gaps; `out_ready` pattern 1,0,0,1,…
  - Packed vectors match the input order.
  - `out_data` is stable during stalls.
  - No element is dropped or duplicated.
- **Pass-through.** Responder returns 0xFFFF in even slices and 0x0000 in odd slices.
  - Output is 0xFFFF,0,0xFFFF,0,… unchanged.
- **Timeout.** TIMEOUT_CYCLES=16; responder never asserts `done`.
  - `timeout`=1 and `in_ready`=1 after 16 WAIT cycles; no `out_valid`.
  - The next operation with a live responder completes correctly, and `timeout` stays 1.
- **Reset mid-DRAIN.** Assert reset after 3 of 8 outputs.
  - The next edge gives all reset values.
  - The following operation outputs its own element 0 first.
- **Input outside LOAD.** Hold `in_valid`=1 through WAIT and DRAIN.
  - `in_ready`=0 throughout.
  - The held pair is accepted as element 0 in the cycle after the drain completes.
